mpsoc_msi_wb_arbiter: RTL and testbench
=======================================

// Module: mpsoc_msi_wb_arbiter
// PURPOSE
//  Round-robin arbiter sharing one Wishbone slave port (typically the master side of the address-decode mux)
//  between NUM_MASTERS requesters. Grant is locked per bus cycle (wbm_cyc_i high), so bursts and RMW
//  sequences are never split. Responses are routed only to the granted master.
// PARAMETERS
//  DW             32  data width
//  AW             32  address width
//  NUM_MASTERS    2   number of requesting masters (>=1)
//  TIMEOUT_CYCLES 255 stall cycles before watchdog error (MPSOC_MSI_WB_ARB_TIMEOUT_EN only, >=2)
// PORTS
//  wb_clk_i   in  1              clock
//  wb_rst_i   in  1              reset, asynchronous, active-high
//  wbm_adr_i  in  [NM][AW]       master address
//  wbm_dat_i  in  [NM][DW]       master write data
//  wbm_sel_i  in  [NM][4]        master byte select
//  wbm_we_i   in  [NM]           master write enable
//  wbm_cyc_i  in  [NM]           master cycle (request)
//  wbm_stb_i  in  [NM]           master strobe
//  wbm_cti_i  in  [NM][3]        master cycle type
//  wbm_bte_i  in  [NM][2]        master burst type
//  wbm_dat_o  out [NM][DW]       read data (all masters, broadcast)
//  wbm_ack_o  out [NM]           ack, granted master only
//  wbm_err_o  out [NM]           err, granted master only
//  wbm_rty_o  out [NM]           rty, granted master only
//  wbs_adr_o/dat_o/sel_o/we_o/cyc_o/stb_o/cti_o/bte_o  out  AW/DW/4/1/1/1/3/2  to slave
//  wbs_dat_i/ack_i/err_i/rty_i  in  DW/1/1/1  from slave
//  grant_o    out NM             one-hot current grant (debug/status)
// BEHAVIOUR
//  - FSM IDLE/BUSY; regs: state, grant_idx (clog2(NM), min 1 bit), last_idx.
//  - Reset: state=IDLE, grant_idx=0, last_idx=NM-1 (master 0 wins first), grant_o=0,
//    wbs_cyc_o=wbs_stb_o=0, all wbm_ack/err/rty_o=0; timeout counter=0.
//  - IDLE: if |wbm_cyc_i, pick first set cyc scanning last_idx+1, +2, ... modulo NM (wrap NM-1 -> 0);
//    grant_idx<=winner, state<=BUSY. Arbitration latency: 1 cycle from cyc to wbs_cyc_o.
//  - BUSY: wbs_* request fields = wbm_*[grant_idx] combinationally; wbs_cyc_o=wbm_cyc_i[grant_idx],
//    wbs_stb_o=wbm_stb_i[grant_idx]. ack/err/rty from slave go to grant_idx only, others 0.
//  - BUSY exit: when wbm_cyc_i[grant_idx]==0 -> state<=IDLE, last_idx<=grant_idx, wbs_cyc_o low
//    that same cycle; re-arbitration next cycle (1 idle bus cycle between owners, no back-to-back).
//  - IDLE: wbs_cyc_o=wbs_stb_o=0; other wbs_* follow master grant_idx (don't-care); grant_o=0.
//  - grant_o = one-hot(grant_idx) in BUSY, 0 in IDLE.
//  - Simultaneous requests: round-robin order only; a master dropping cyc in the grant cycle gets
//    grant for one cycle then releases. NM=1: always master 0, same FSM/latency.
//  - Reset mid-transfer: immediate return to reset values; in-flight slave response discarded.
//  - Requests from non-granted masters are held off (no ack) until granted; never dropped.
// CONFIGURATION
//  MPSOC_MSI_WB_ARB_TIMEOUT_EN defined: counter (clog2(TIMEOUT_CYCLES+1) bits) counts BUSY cycles with
//    wbs_stb_o=1 and !(ack|err|rty); cleared on any response, on IDLE, on stb low. On reaching
//    TIMEOUT_CYCLES: one-cycle wbm_err_o to granted master, wbs_cyc_o/stb_o forced 0 that cycle,
//    counter cleared; state unchanged (master must drop cyc to release).
//  Undefined: no counter, no forced error; a hung slave holds the grant indefinitely.
// TESTING
//  1 Reset, m0 cyc/stb adr=0x100, slave acks 2 cycles later -> wbs_cyc_o 1 cycle after, ack only on m0.
//  2 m0 and m1 cyc together, each 1-beat -> m0 first, 1 idle cycle, then m1; next pair -> m0 again.
//  3 NM=4, m1 burst cti=3'b010 4 beats while m2 requests -> 4 acks to m1 uninterrupted, then m2.
//  4 Assert wb_rst_i mid-burst of m1 -> wbs_cyc_o=0, grant_o=0 asynchronously; next winner is m0.
//  5 TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> wbm_err_o[granted] high on 8th stall cycle.
//  6 Slave err on m1 read -> wbm_err_o[1]=1, wbm_err_o[0]=0, wbm_ack_o all 0.

Source files
------------

// File: rtl/mpsoc_msi_wb_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave port, grant locked per bus cycle.
// Optional stall watchdog enabled by defining MPSOC_MSI_WB_ARB_TIMEOUT_EN.
module mpsoc_msi_wb_arbiter #(
    parameter int DW             = 32,
    parameter int AW             = 32,
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              wb_clk_i,
    input  logic                              wb_rst_i,

    input  logic [NUM_MASTERS-1:0][AW-1:0]    wbm_adr_i,
    input  logic [NUM_MASTERS-1:0][DW-1:0]    wbm_dat_i,
    input  logic [NUM_MASTERS-1:0][3:0]       wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]            wbm_we_i,
    input  logic [NUM_MASTERS-1:0]            wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]            wbm_stb_i,
    input  logic [NUM_MASTERS-1:0][2:0]       wbm_cti_i,
    input  logic [NUM_MASTERS-1:0][1:0]       wbm_bte_i,
    output logic [NUM_MASTERS-1:0][DW-1:0]    wbm_dat_o,
    output logic [NUM_MASTERS-1:0]            wbm_ack_o,
    output logic [NUM_MASTERS-1:0]            wbm_err_o,
    output logic [NUM_MASTERS-1:0]            wbm_rty_o,

    output logic [AW-1:0]                     wbs_adr_o,
    output logic [DW-1:0]                     wbs_dat_o,
    output logic [3:0]                        wbs_sel_o,
    output logic                              wbs_we_o,
    output logic                              wbs_cyc_o,
    output logic                              wbs_stb_o,
    output logic [2:0]                        wbs_cti_o,
    output logic [1:0]                        wbs_bte_o,
    input  logic [DW-1:0]                     wbs_dat_i,
    input  logic                              wbs_ack_i,
    input  logic                              wbs_err_i,
    input  logic                              wbs_rty_i,

    output logic [NUM_MASTERS-1:0]            grant_o
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state;
    logic [IW-1:0]          grant_idx;
    logic [IW-1:0]          last_idx;
    logic [IW-1:0]          next_idx;
    logic [NUM_MASTERS-1:0] next_onehot;
    logic                   busy;
    logic                   cyc_raw;
    logic                   stb_raw;
    logic                   timeout_hit;

    assign busy = (state == BUSY);

    // Scan starting just after the last owner so every requester is reached within NUM_MASTERS grants.
    always_comb begin
        logic                found;
        logic [IW-1:0]       c_idx;
        int unsigned         c;
        found       = 1'b0;
        next_idx    = '0;
        next_onehot = '0;
        c           = 0;
        c_idx       = '0;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            c     = (int'(last_idx) + i) % NUM_MASTERS;
            c_idx = c[IW-1:0];
            if (!found && wbm_cyc_i[c_idx]) begin
                found    = 1'b1;
                next_idx = c_idx;
            end
        end
        next_onehot[next_idx] = 1'b1;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            grant_idx <= '0;
            last_idx  <= IW'(NUM_MASTERS - 1);
            grant_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|wbm_cyc_i) begin
                        grant_idx <= next_idx;
                        grant_o   <= next_onehot;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (!wbm_cyc_i[grant_idx]) begin
                        last_idx <= grant_idx;
                        grant_o  <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cyc_raw = busy & wbm_cyc_i[grant_idx];
    assign stb_raw = busy & wbm_stb_i[grant_idx];

`ifdef MPSOC_MSI_WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] to_cnt;
    logic          stall;

    assign stall       = stb_raw & ~(wbs_ack_i | wbs_err_i | wbs_rty_i);
    assign timeout_hit = stall && (to_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            to_cnt <= '0;
        end else if (!stall || timeout_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        wbs_adr_o = wbm_adr_i[grant_idx];
        wbs_dat_o = wbm_dat_i[grant_idx];
        wbs_sel_o = wbm_sel_i[grant_idx];
        wbs_we_o  = wbm_we_i[grant_idx];
        wbs_cti_o = wbm_cti_i[grant_idx];
        wbs_bte_o = wbm_bte_i[grant_idx];
        wbs_cyc_o = cyc_raw & ~timeout_hit;
        wbs_stb_o = stb_raw & ~timeout_hit;
    end

    always_comb begin
        wbm_ack_o = '0;
        wbm_err_o = '0;
        wbm_rty_o = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            wbm_dat_o[i] = wbs_dat_i;
        end
        if (busy) begin
            wbm_ack_o[grant_idx] = wbs_ack_i;
            wbm_err_o[grant_idx] = wbs_err_i | timeout_hit;
            wbm_rty_o[grant_idx] = wbs_rty_i;
        end
    end

endmodule

// File: tb/tb_mpsoc_msi_wb_arbiter.sv
// Directed bench for mpsoc_msi_wb_arbiter with four masters; watchdog case runs when
// MPSOC_MSI_WB_ARB_TIMEOUT_EN is defined.
module tb_mpsoc_msi_wb_arbiter;

    localparam int NM = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NM-1:0][31:0]  m_adr;
    logic [NM-1:0][31:0]  m_dat;
    logic [NM-1:0][3:0]   m_sel;
    logic [NM-1:0]        m_we;
    logic [NM-1:0]        m_cyc;
    logic [NM-1:0]        m_stb;
    logic [NM-1:0][2:0]   m_cti;
    logic [NM-1:0][1:0]   m_bte;
    logic [NM-1:0][31:0]  m_dat_o;
    logic [NM-1:0]        m_ack;
    logic [NM-1:0]        m_err;
    logic [NM-1:0]        m_rty;
    logic [31:0]          s_adr;
    logic [31:0]          s_dat_o;
    logic [3:0]           s_sel;
    logic                 s_we;
    logic                 s_cyc;
    logic                 s_stb;
    logic [2:0]           s_cti;
    logic [1:0]           s_bte;
    logic [31:0]          s_dat_i;
    logic                 s_ack;
    logic                 s_err;
    logic                 s_rty;
    logic [NM-1:0]        grant;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mpsoc_msi_wb_arbiter #(
        .DW(32), .AW(32), .NUM_MASTERS(NM), .TIMEOUT_CYCLES(8)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
        .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
        .wbm_dat_o(m_dat_o), .wbm_ack_o(m_ack), .wbm_err_o(m_err), .wbm_rty_o(m_rty),
        .wbs_adr_o(s_adr), .wbs_dat_o(s_dat_o), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
        .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_cti_o(s_cti), .wbs_bte_o(s_bte),
        .wbs_dat_i(s_dat_i), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
        .grant_o(grant)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0;
        m_cyc = '0; m_stb = '0; m_cti = '0; m_bte = '0;
        s_dat_i = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Each step: wait for a falling edge, drive, then settle 1 time unit before checking.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        #1;
        check("rst_grant", grant, 4'b0000);
        check("rst_cyc", s_cyc, 1'b0);
        check("rst_ack", m_ack, 4'b0000);
        do_reset();

        // Single master, ack two cycles after request
        step(); m_cyc = 4'b0001; m_stb = 4'b0001; m_adr[0] = 32'h100; #1;
        check("t1_latency_cyc", s_cyc, 1'b0);
        step(); #1;
        check("t1_cyc", s_cyc, 1'b1);
        check("t1_adr", s_adr, 32'h100);
        check("t1_grant", grant, 4'b0001);
        check("t1_no_ack_yet", m_ack, 4'b0000);
        step(); s_ack = 1'b1; s_dat_i = 32'hcafe_f00d; #1;
        check("t1_ack", m_ack, 4'b0001);
        check("t1_dat_bcast", m_dat_o[3], 32'hcafe_f00d);
        step(); m_cyc = '0; m_stb = '0; s_ack = 1'b0; #1;
        check("t1_release_cyc", s_cyc, 1'b0);
        step(); #1;
        check("t1_idle_grant", grant, 4'b0000);

        // Two simultaneous requesters after reset
        do_reset();
        step(); m_cyc = 4'b0011; m_stb = 4'b0011; m_adr[0] = 32'h200; m_adr[1] = 32'h300; #1;
        check("t2_idle_cyc", s_cyc, 1'b0);
        step(); s_ack = 1'b1; #1;
        check("t2_grant_m0", grant, 4'b0001);
        check("t2_ack_m0", m_ack, 4'b0001);
        check("t2_adr_m0", s_adr, 32'h200);
        step(); m_cyc = 4'b0010; m_stb = 4'b0010; s_ack = 1'b0; #1;
        check("t2_m0_drop_cyc", s_cyc, 1'b0);
        check("t2_m0_drop_grant", grant, 4'b0001);
        step(); #1;
        check("t2_gap_cyc", s_cyc, 1'b0);
        check("t2_gap_grant", grant, 4'b0000);
        step(); s_ack = 1'b1; #1;
        check("t2_grant_m1", grant, 4'b0010);
        check("t2_ack_m1", m_ack, 4'b0010);
        check("t2_adr_m1", s_adr, 32'h300);
        step(); m_cyc = '0; m_stb = '0; s_ack = 1'b0;
        step(); m_cyc = 4'b0011; m_stb = 4'b0011;
        step(); #1;
        check("t2_second_pair_m0", grant, 4'b0001);
        step(); m_cyc = '0; m_stb = '0;

        // m1 incrementing burst while m2 waits (last owner is m0)
        step(); m_cyc = 4'b0110; m_stb = 4'b0110; m_cti[1] = 3'b010; m_cti[2] = 3'b111;
        for (int i = 0; i < 4; i++) begin
            step(); s_ack = 1'b1; if (i == 3) m_cti[1] = 3'b111; #1;
            check($sformatf("t3_beat%0d_ack", i), m_ack, 4'b0010);
            check($sformatf("t3_beat%0d_grant", i), grant, 4'b0010);
        end
        check("t3_last_cti", s_cti, 3'b111);
        step(); m_cyc = 4'b0100; m_stb = 4'b0100; s_ack = 1'b0; #1;
        check("t3_m2_held_off", m_ack, 4'b0000);
        step();
        step(); #1;
        check("t3_grant_m2", grant, 4'b0100);
        check("t3_cti_m2", s_cti, 3'b111);
        step(); m_cyc = '0; m_stb = '0;

        // Asynchronous reset during an m1 burst
        step(); m_cyc = 4'b0010; m_stb = 4'b0010; m_cti[1] = 3'b010;
        step(); s_ack = 1'b1; #1;
        check("t4_grant_m1", grant, 4'b0010);
        #2; rst = 1'b1; #1;
        check("t4_async_cyc", s_cyc, 1'b0);
        check("t4_async_grant", grant, 4'b0000);
        check("t4_async_ack", m_ack, 4'b0000);
        step(); rst = 1'b0; s_ack = 1'b0; m_cyc = 4'b0011; m_stb = 4'b0011;
        step(); #1;
        check("t4_post_rst_m0", grant, 4'b0001);

        // Slave error on an m1 read
        step(); m_cyc = 4'b0010; m_stb = 4'b0010; m_we = '0;
        step(); step(); s_err = 1'b1; #1;
        check("t6_grant_m1", grant, 4'b0010);
        check("t6_err", m_err, 4'b0010);
        check("t6_no_ack", m_ack, 4'b0000);
        step(); s_err = 1'b0; s_rty = 1'b1; #1;
        check("t6_rty", m_rty, 4'b0010);
        step(); m_cyc = '0; m_stb = '0; s_rty = 1'b0;

`ifdef MPSOC_MSI_WB_ARB_TIMEOUT_EN
        // Hung slave: watchdog error on the 8th stall cycle
        do_reset();
        step(); m_cyc = 4'b0001; m_stb = 4'b0001;
        for (int k = 1; k <= 9; k++) begin
            step(); #1;
            check($sformatf("t5_err_%0d", k), m_err, (k == 8) ? 4'b0001 : 4'b0000);
            check($sformatf("t5_cyc_%0d", k), s_cyc, (k == 8) ? 1'b0 : 1'b1);
        end
        check("t5_grant_kept", grant, 4'b0001);
        step(); m_cyc = '0; m_stb = '0;
`endif

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
